alu_frame_tx: RTL and testbench

//  Serial frame transmitter for the serial ALU input link. Accepts one operation (A, B, op),

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_tx_shifter.sv | 44 ++++
 rtl/alu_frame_tx.sv | 128 ++++++++++++
 tb/tb_alu_frame_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the serial ALU link: operation codes, frame word
// layout constants and the CRC4 used in the CTL word.
package alu_pkg;

    typedef enum logic [2:0] {
        AND_op   = 3'b000,
        OR_op    = 3'b001,
        ERROR_op = 3'b010,
        ADD_op   = 3'b100,
        SUB_op   = 3'b101,
        RST_op   = 3'b110
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CTL,
        FIN
    } tx_state_t;

    localparam int   WORD_BITS    = 11;
    localparam logic TYPE_DATA    = 1'b0;
    localparam logic TYPE_CTL     = 1'b1;
    localparam int   N_DATA_WORDS = 8;

    // x^4+x+1, init 0, MSB first over {B, A, 1'b1, op}.
    function automatic bit [3:0] crc4(input bit [67:0] d);
        bit [3:0] c;
        bit       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = d[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
        end
        return c;
    endfunction

    function automatic logic [WORD_BITS-1:0] make_word(input logic typ, input logic [7:0] payload);
        return {1'b0, typ, payload, 1'b1};
    endfunction

endpackage

// File: rtl/alu_tx_shifter.sv
// Word shift register with baud timing: loads an 11-bit word, presents its MSB on
// sout and shifts in idle '1's every BIT_CYCLES clocks while running.
module alu_tx_shifter
    import alu_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 run,
    input  logic [WORD_BITS-1:0] word,
    output logic                 sout,
    output logic                 shift
);

    localparam int             BW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BW-1:0]  BAUD_MAX = BW'(BIT_CYCLES - 1);

    logic [BW-1:0]        baud_cnt;
    logic [WORD_BITS-1:0] sreg;

    assign shift = run && (baud_cnt == BAUD_MAX);
    assign sout  = sreg[WORD_BITS-1];

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            sreg     <= '1;
        end else if (load) begin
            baud_cnt <= '0;
            sreg     <= word;
        end else if (run) begin
            if (shift) begin
                baud_cnt <= '0;
                sreg     <= {sreg[WORD_BITS-2:0], 1'b1};
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_frame_tx.sv
// Serial frame transmitter: sends 8 DATA words (B then A, MSB byte first) and one
// CTL word carrying op and CRC4, then pulses done.
module alu_frame_tx
    import alu_pkg::*;
#(
    parameter int BIT_CYCLES = 1,
    parameter int GAP_BITS   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  operation_t  op,
    input  logic        inject_crc,
    output logic        sout,
    output logic        done,
    output logic        req_err
);

    localparam int             LAST_BIT   = WORD_BITS - 1 + GAP_BITS;
    localparam int             CW         = $clog2(LAST_BIT + 1);
    localparam logic [CW-1:0]  LAST_BIT_C = CW'(LAST_BIT);
    localparam logic [2:0]     LAST_WORD  = 3'(N_DATA_WORDS - 1);

    tx_state_t state, state_next;

    logic [2:0]           word_cnt;
    logic [CW-1:0]        bit_cnt;
    logic                 pend;
    logic [63:0]          data_q;
    logic [7:0]           ctl_q;
    logic                 rej_q;

    logic                 accept;
    logic                 reject;
    logic                 bit_end;
    logic                 word_end;
    logic                 load;
    logic                 run;
    logic [2:0]           sel;
    logic [7:0]           data_byte;
    logic [WORD_BITS-1:0] load_word;

    assign ready     = (state == IDLE) || (state == FIN);
    assign done      = (state == FIN);
    assign accept    = ready && start && (op != RST_op);
    assign reject    = ready && start && (op == RST_op);
    assign word_end  = bit_end && (bit_cnt == LAST_BIT_C);

    // The first word of a frame loads one cycle after accept; later ones at the end of the previous slot.
    assign sel       = pend ? word_cnt : word_cnt + 3'd1;
    assign data_byte = data_q[{3'd7 - sel, 3'b000} +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        run        = 1'b0;
        load_word  = make_word(TYPE_CTL, ctl_q);
        case (state)
            IDLE: ;
            DATA: begin
                if (pend || word_cnt != LAST_WORD) load_word = make_word(TYPE_DATA, data_byte);
                if (pend) begin
                    load = 1'b1;
                end else begin
                    run = 1'b1;
                    if (word_end) begin
                        load = 1'b1;
                        if (word_cnt == LAST_WORD) state_next = CTL;
                    end
                end
            end
            CTL: begin
                run = 1'b1;
                if (word_end) state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (accept) state_next = DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            bit_cnt  <= '0;
            pend     <= 1'b0;
            data_q   <= '0;
            ctl_q    <= '0;
            rej_q    <= 1'b0;
            req_err  <= 1'b0;
        end else begin
            pend    <= accept;
            rej_q   <= reject;
            req_err <= rej_q;
            if (accept) begin
                data_q   <= {B, A};
                ctl_q    <= {1'b0, op, crc4({B, A, 1'b1, op}) ^ {3'b000, inject_crc}};
                word_cnt <= '0;
            end else if (state == DATA && word_end) begin
                word_cnt <= word_cnt + 3'd1;
            end
            if (load || word_end) bit_cnt <= '0;
            else if (bit_end)     bit_cnt <= bit_cnt + CW'(1);
        end
    end

    alu_tx_shifter #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_shifter (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .run  (run),
        .word (load_word),
        .sout (sout),
        .shift(bit_end)
    );

endmodule

// File: tb/tb_alu_frame_tx.sv
// Bench for alu_frame_tx: two instances (fast/no-gap and slow/gapped) checked cycle
// by cycle against a bit-stream model built from the frame rules.
module tb_alu_frame_tx;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2;
    logic [31:0] a_s, b_s;
    operation_t  op_s;
    logic        inj_s;
    logic        ready1, sout1, done1, err1;
    logic        ready2, sout2, done2, err2;

    int total = 0;
    int bad   = 0;

    bit exp_q[$];
    bit cap_q[$];

    always #5 clk = ~clk;

    alu_frame_tx #(.BIT_CYCLES(1), .GAP_BITS(0)) u1 (
        .clk(clk), .rst(rst), .start(start1), .ready(ready1), .A(a_s), .B(b_s),
        .op(op_s), .inject_crc(inj_s), .sout(sout1), .done(done1), .req_err(err1)
    );

    alu_frame_tx #(.BIT_CYCLES(4), .GAP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .ready(ready2), .A(a_s), .B(b_s),
        .op(op_s), .inject_crc(inj_s), .sout(sout2), .done(done2), .req_err(err2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Remainder of M(x)*x^4 modulo x^4+x+1 by long division.
    function automatic logic [3:0] model_crc(input logic [67:0] m);
        logic [71:0] r;
        r = {m, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [7:0] model_ctl(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] o, input bit inj);
        return {1'b0, o, model_crc({b, a, 1'b1, o}) ^ {3'b000, inj}};
    endfunction

    // Expected sout, one entry per clock, from the first start bit to the last gap cycle.
    function automatic void build_frame(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] o, input bit inj,
                                        input int bc, input int g);
        logic [7:0]  bytes[9];
        logic [10:0] w;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            bytes[i]     = b[31 - 8*i -: 8];
            bytes[i + 4] = a[31 - 8*i -: 8];
        end
        bytes[8] = model_ctl(a, b, o, inj);
        for (int wi = 0; wi < 9; wi++) begin
            w = {1'b0, (wi == 8), bytes[wi], 1'b1};
            for (int k = 10; k >= 0; k--)
                for (int c = 0; c < bc; c++) exp_q.push_back(w[k]);
            for (int c = 0; c < g * bc; c++) exp_q.push_back(1'b1);
        end
    endfunction

    task automatic sample(input int which, output logic s, output logic r,
                          output logic d, output logic e);
        if (which == 1) begin s = sout1; r = ready1; d = done1; e = err1; end
        else            begin s = sout2; r = ready2; d = done2; e = err2; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at a negedge; leaves at the negedge of the done cycle so a chained call
    // exercises accept during the done cycle.
    task automatic run_frame(input int which, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] o, input bit inj, output logic [7:0] ctl_seen);
        int   bc, g, len, base;
        logic s, r, d, e;
        bc  = (which == 1) ? 1 : 4;
        g   = (which == 1) ? 0 : 2;
        len = 9 * (11 + g) * bc;
        build_frame(a, b, o, inj, bc, g);
        sample(which, s, r, d, e);
        check("ready_before_start", r, 1'b1);
        a_s = a; b_s = b; op_s = operation_t'(o); inj_s = inj;
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        a_s = $urandom; b_s = $urandom; op_s = operation_t'(3'($urandom_range(0, 7))); inj_s = 1'($urandom_range(0, 1));
        sample(which, s, r, d, e);
        check("accept_cycle {sout,ready,done}", {s, r, d}, 3'b100);
        cap_q.delete();
        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            sample(which, s, r, d, e);
            check("frame sout", s, exp_q[j-1]);
            check("frame {ready,done}", {r, d}, 2'b00);
            cap_q.push_back(s);
        end
        @(negedge clk);
        sample(which, s, r, d, e);
        check("done cycle {sout,ready,done}", {s, r, d}, 3'b111);
        base = (8 * (11 + g) + 2) * bc;
        for (int n = 0; n < 8; n++) ctl_seen[7-n] = cap_q[base + n * bc];
    endtask

    typedef struct {
        string       name;
        int          which;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        bit          inj;
        bit          known;
        logic [7:0]  ctl_exp;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0]  ctl;
        logic [31:0] ra, rb;
        logic [2:0]  ro;
        bit          ri;
        logic        s, r, d, e;

        tbl[0] = '{"and_zero",    1, 32'h0,        32'h0,        3'b000, 1'b0, 1'b1, 8'h0B};
        tbl[1] = '{"add_bytes",   1, 32'h01020304, 32'hAABBCCDD, 3'b100, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{"error_op",    1, 32'h0,        32'h0,        3'b010, 1'b0, 1'b1, 8'h2D};
        tbl[3] = '{"inject_crc",  1, 32'h0,        32'h0,        3'b000, 1'b1, 1'b1, 8'h0A};
        tbl[4] = '{"slow_gapped", 2, 32'h0,        32'h0,        3'b000, 1'b0, 1'b1, 8'h0B};
        tbl[5] = '{"unlisted_op", 1, 32'hDEADBEEF, 32'h12345678, 3'b011, 1'b0, 1'b0, 8'h00};

        start1 = 1'b0; start2 = 1'b0;
        a_s = '0; b_s = '0; op_s = AND_op; inj_s = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("reset dut1 {sout,ready,done,req_err}", {sout1, ready1, done1, err1}, 4'b1100);
        check("reset dut2 {sout,ready,done,req_err}", {sout2, ready2, done2, err2}, 4'b1100);
        rst = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle dut1 {sout,ready,done}", {sout1, ready1, done1}, 3'b110);
            check("idle dut2 {sout,ready,done}", {sout2, ready2, done2}, 3'b110);
        end

        // Table vectors; entries 0..3 chain back to back through the done cycle.
        for (int i = 0; i < 6; i++) begin
            if (i >= 4) idle(3);
            run_frame(tbl[i].which, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].inj, ctl);
            if (tbl[i].known) begin
                check({"ctl ", tbl[i].name}, ctl, tbl[i].ctl_exp);
            end else begin
                check({"ctl op ", tbl[i].name}, ctl[6:4], tbl[i].op);
                check({"ctl crc ", tbl[i].name}, ctl[3:0], model_crc({tbl[i].b, tbl[i].a, 1'b1, tbl[i].op}));
                check({"ctl msb ", tbl[i].name}, ctl[7], 1'b0);
            end
        end
        check("pkg crc4 vs model", crc4({32'hAABBCCDD, 32'h01020304, 1'b1, 3'b100}),
              model_crc({32'hAABBCCDD, 32'h01020304, 1'b1, 3'b100}));

        // RST_op is rejected with a req_err pulse one cycle after the sampling edge.
        idle(2);
        op_s = RST_op; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        check("rst_op k {sout,ready,req_err}", {sout1, ready1, err1}, 3'b110);
        @(negedge clk);
        check("rst_op k+1 {sout,ready,req_err}", {sout1, ready1, err1}, 3'b111);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_op after {sout,ready,req_err,done}", {sout1, ready1, err1, done1}, 4'b1100);
        end

        // Reset in the middle of word 3 (B[7:0]=0 so the line is low beforehand).
        a_s = 32'h55AA55AA; b_s = 32'h12345600; op_s = ADD_op; inj_s = 1'b0;
        build_frame(a_s, b_s, 3'b100, 1'b0, 1, 0);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (1 + 3 * 11 + 4) @(negedge clk);
        check("pre-abort sout", sout1, exp_q[37]);
        #2 rst = 1'b1;
        #1 check("abort {sout,ready,done}", {sout1, ready1, done1}, 3'b110);
        repeat (2) begin
            @(negedge clk);
            check("abort hold {sout,done}", {sout1, done1}, 2'b10);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post-abort {sout,ready,done}", {sout1, ready1, done1}, 3'b110);
        end
        run_frame(1, 32'hCAFEF00D, 32'h0BADBEEF, 3'b001, 1'b0, ctl);
        check("post-abort ctl", ctl, model_ctl(32'hCAFEF00D, 32'h0BADBEEF, 3'b001, 1'b0));

        // Random frames against the model.
        for (int i = 0; i < 10; i++) begin
            ra = $urandom; rb = $urandom;
            ro = 3'($urandom_range(0, 7));
            if (ro == 3'b110) ro = 3'b111;
            ri = 1'($urandom_range(0, 1));
            idle($urandom_range(0, 2));
            run_frame((i % 5 == 4) ? 2 : 1, ra, rb, ro, ri, ctl);
            check("random ctl", ctl, model_ctl(ra, rb, ro, ri));
        end

        @(negedge clk);
        sample(1, s, r, d, e);
        check("final dut1 {sout,ready,done}", {s, r, d}, 3'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
